// File: rtl/bit_error_checker_if.sv
// ---------------------------------------------------------------------------
// bit_error_checker_if
//
// Purpose:
//   Bundles the control, receive-bit and result signals of the receive-side
//   PRBS bit error checker so the checker and its driver connect through a
//   single port.
//
// Parameters:
//   CNT_W             width of the bit and error counters
//
// Signals:
//   start             one-cycle pulse: reseed, clear counters, arm a frame
//   modulation_order  bits-per-symbol select, sampled on start
//                     (000 -> 2, 001 -> 4, 010 -> 6, others -> 2)
//   rx_bit_valid      rx_bit carries a demapped bit this cycle
//   rx_bit            demapped receive bit
//   busy              frame in progress
//   done              frame complete, held until the next start
//   bit_err_valid     one-cycle strobe per compared bit
//   bit_err           mismatch flag qualified by bit_err_valid
//   bit_count         bits compared in the current/last frame
//   error_count       mismatches in the current/last frame (saturating)
//
// Modports:
//   master            the side that drives start and the receive bits
//   slave             the checker itself
// ---------------------------------------------------------------------------
interface bit_error_checker_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [2:0]       modulation_order;
    logic             rx_bit_valid;
    logic             rx_bit;
    logic             busy;
    logic             done;
    logic             bit_err_valid;
    logic             bit_err;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] error_count;

    modport master (
        output start,
        output modulation_order,
        output rx_bit_valid,
        output rx_bit,
        input  busy,
        input  done,
        input  bit_err_valid,
        input  bit_err,
        input  bit_count,
        input  error_count
    );

    modport slave (
        input  start,
        input  modulation_order,
        input  rx_bit_valid,
        input  rx_bit,
        output busy,
        output done,
        output bit_err_valid,
        output bit_err,
        output bit_count,
        output error_count
    );
endinterface

// File: rtl/bit_error_checker.sv
// ---------------------------------------------------------------------------
// bit_error_checker
//
// Purpose:
//   Receive-side counterpart of the transmit PRBS-15 source in the OTFS 4QAM
//   chain. A local copy of the transmit LFSR (x^15 + x^14 + 1, seed 7FFF) is
//   compared bit by bit against the demapped receive stream. Over one frame
//   of NUM_SYMBOLS x bits-per-symbol bits it counts compared bits and bit
//   errors, then flags the frame as done.
//
// Parameters:
//   NUM_SYMBOLS       QAM symbols per frame (1..4095)
//   CNT_W             width of the bit and error counters
//
// Ports:
//   clk               system clock, all logic on the rising edge
//   rst_n             asynchronous active-low reset
//   bus               bit_error_checker_if slave modport:
//                       start / modulation_order / rx_bit_valid / rx_bit in,
//                       busy / done / bit_err_valid / bit_err /
//                       bit_count / error_count out (all registered)
// ---------------------------------------------------------------------------
module bit_error_checker #(
    parameter int NUM_SYMBOLS = 64,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bit_error_checker_if.slave bus
);

    // 15 bits is enough for the largest frame, 4095 symbols x 6 bits = 24570.
    localparam int              FB_W = 15;
    localparam logic [14:0]     SEED = 15'h7FFF;
    localparam logic [FB_W-1:0] NUM_SYMBOLS_V = FB_W'(NUM_SYMBOLS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [14:0]       lfsr;
    logic [FB_W-1:0]   frame_bits;
    logic [FB_W-1:0]   accepted;
    logic              busy_q;
    logic              done_q;
    logic              bit_err_valid_q;
    logic              bit_err_q;
    logic [CNT_W-1:0]  bit_count_q;
    logic [CNT_W-1:0]  error_count_q;

    logic [2:0]        bps_sel;
    logic              mismatch;
    logic [FB_W-1:0]   accepted_next;
    logic              last_bit;

    // One step of the PRBS-15 generator, identical to the transmitter.
    function automatic logic [14:0] prbs_next(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    // Bits per symbol for the requested modulation; unknown codes fall back
    // to 4QAM so a bad select still yields a finite frame.
    always_comb begin
        bps_sel = 3'd2;
        case (bus.modulation_order)
            3'b000:  bps_sel = 3'd2;
            3'b001:  bps_sel = 3'd4;
            3'b010:  bps_sel = 3'd6;
            default: bps_sel = 3'd2;
        endcase
    end

    // The expected bit is always the LFSR MSB. The frame ends on the
    // accepted bit that brings the internal count up to frame_bits.
    // The internal count is full width, so the frame length is honoured
    // even when CNT_W is too narrow to hold it.
    assign mismatch      = bus.rx_bit ^ lfsr[14];
    assign accepted_next = accepted + FB_W'(1);
    assign last_bit      = (accepted_next == frame_bits);

    // Frame controller: start (in any state) reseeds and rearms; in RUN each
    // valid bit is compared, counted and strobed out one cycle later. The
    // frame length is captured as a product at start, so bps itself does not
    // need its own register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            lfsr            <= SEED;
            frame_bits      <= '0;
            accepted        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            bit_err_valid_q <= 1'b0;
            bit_err_q       <= 1'b0;
            bit_count_q     <= '0;
            error_count_q   <= '0;
        end else begin
            bit_err_valid_q <= 1'b0;
            if (bus.start) begin
                state         <= RUN;
                lfsr          <= SEED;
                frame_bits    <= NUM_SYMBOLS_V * FB_W'(bps_sel);
                accepted      <= '0;
                busy_q        <= 1'b1;
                done_q        <= 1'b0;
                bit_err_q     <= 1'b0;
                bit_count_q   <= '0;
                error_count_q <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (bus.rx_bit_valid) begin
                            lfsr            <= prbs_next(lfsr);
                            accepted        <= accepted_next;
                            bit_err_valid_q <= 1'b1;
                            bit_err_q       <= mismatch;
                            // Both visible counters saturate rather than wrap.
                            if (bit_count_q != '1) begin
                                bit_count_q <= bit_count_q + CNT_W'(1);
                            end
                            if (mismatch && (error_count_q != '1)) begin
                                error_count_q <= error_count_q + CNT_W'(1);
                            end
                            if (last_bit) begin
                                state  <= DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // IDLE and DONE ignore rx_bit_valid and hold everything.
                    end
                endcase
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.bit_err_valid = bit_err_valid_q;
    assign bus.bit_err       = bit_err_q;
    assign bus.bit_count     = bit_count_q;
    assign bus.error_count   = error_count_q;

endmodule

// File: tb/tb_bit_error_checker.sv
// ---------------------------------------------------------------------------
// tb_bit_error_checker
//
// Purpose:
//   Self-checking bench for bit_error_checker. One instance (8 symbols,
//   16-bit counters) covers golden, stuck-high, 16QAM-with-gaps, restart and
//   reset frames; a second instance (16 symbols, 4-bit counters) covers
//   error counter saturation. Expected per-bit mismatch flags are queued as
//   stimulus is driven and popped when the checker strobes bit_err_valid.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_bit_error_checker;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bit_error_checker_if #(.CNT_W(16)) ifa ();
    bit_error_checker_if #(.CNT_W(4))  ifs ();

    bit_error_checker #(.NUM_SYMBOLS(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    bit_error_checker #(.NUM_SYMBOLS(16), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs)
    );

    int          compared   = 0;
    int          mismatched = 0;
    int          strobe_cnt = 0;
    logic        expq[$];
    logic        mon_exp;
    logic [14:0] gen_lfsr;
    logic [14:0] model_lfsr;
    logic        model_run;
    int          model_cnt;
    int          model_frame;

    // Single comparison point: counts, asserts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Next bit of the transmit PRBS used to build stimulus.
    task automatic nextPrbs(output logic b);
        b        = gen_lfsr[14];
        gen_lfsr = {gen_lfsr[13:0], gen_lfsr[14] ^ gen_lfsr[13]};
    endtask

    // Drive one cycle on the main instance, update the reference model and
    // queue the expected mismatch flag; returns just after the active edge.
    task automatic applyStimulus(input logic st, input logic [2:0] mo,
                                 input logic v, input logic b);
        @(negedge clk);
        ifa.start            = st;
        ifa.modulation_order = mo;
        ifa.rx_bit_valid     = v;
        ifa.rx_bit           = b;
        if (st) begin
            model_lfsr  = 15'h7FFF;
            model_cnt   = 0;
            model_run   = 1'b1;
            model_frame = 8 * ((mo == 3'b001) ? 4 : (mo == 3'b010) ? 6 : 2);
        end else if (model_run && v) begin
            expq.push_back(b ^ model_lfsr[14]);
            model_lfsr = {model_lfsr[13:0], model_lfsr[14] ^ model_lfsr[13]};
            model_cnt++;
            if (model_cnt == model_frame) model_run = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on the saturation instance.
    task automatic applySat(input logic st, input logic v, input logic b);
        @(negedge clk);
        ifs.start            = st;
        ifs.modulation_order = 3'b000;
        ifs.rx_bit_valid     = v;
        ifs.rx_bit           = b;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer plus the busy/done exclusivity check.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ifa.bit_err_valid === 1'b1) begin
                strobe_cnt++;
                if (expq.size() == 0) begin
                    checkOutput("unexpected_strobe", {31'b0, ifa.bit_err_valid}, 32'd0);
                end else begin
                    mon_exp = expq.pop_front();
                    checkOutput("bit_err", {31'b0, ifa.bit_err}, {31'b0, mon_exp});
                end
            end
            checkOutput("busy_done_excl", {31'b0, ifa.busy & ifa.done}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic b;

        rst_n                = 1'b0;
        ifa.start            = 1'b0;
        ifa.modulation_order = 3'b000;
        ifa.rx_bit_valid     = 1'b0;
        ifa.rx_bit           = 1'b0;
        ifs.start            = 1'b0;
        ifs.modulation_order = 3'b000;
        ifs.rx_bit_valid     = 1'b0;
        ifs.rx_bit           = 1'b0;
        gen_lfsr             = 15'h7FFF;
        model_lfsr           = 15'h7FFF;
        model_run            = 1'b0;
        model_cnt            = 0;
        model_frame          = 0;

        // Reset values
        #12;
        checkOutput("rst_busy", {31'b0, ifa.busy}, 32'd0);
        checkOutput("rst_done", {31'b0, ifa.done}, 32'd0);
        checkOutput("rst_bev", {31'b0, ifa.bit_err_valid}, 32'd0);
        checkOutput("rst_bit_err", {31'b0, ifa.bit_err}, 32'd0);
        checkOutput("rst_bit_count", ifa.bit_count, 32'd0);
        checkOutput("rst_error_count", ifa.error_count, 32'd0);
        checkOutput("rst_sat_error_count", ifs.error_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores valid bits
        applyStimulus(1'b0, 3'b000, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b000, 1'b1, 1'b1);
        checkOutput("idle_bev", {31'b0, ifa.bit_err_valid}, 32'd0);
        checkOutput("idle_bit_count", ifa.bit_count, 32'd0);
        checkOutput("idle_busy", {31'b0, ifa.busy}, 32'd0);

        // Golden frame; the valid bit alongside start must be ignored
        gen_lfsr = 15'h7FFF;
        applyStimulus(1'b1, 3'b000, 1'b1, 1'b0);
        strobe_cnt = 0;
        checkOutput("start_busy", {31'b0, ifa.busy}, 32'd1);
        checkOutput("start_done", {31'b0, ifa.done}, 32'd0);
        checkOutput("start_bev", {31'b0, ifa.bit_err_valid}, 32'd0);
        checkOutput("start_bit_count", ifa.bit_count, 32'd0);
        for (int i = 0; i < 16; i++) begin
            nextPrbs(b);
            applyStimulus(1'b0, 3'b000, 1'b1, b);
            if (i == 14) begin
                checkOutput("golden_15_done", {31'b0, ifa.done}, 32'd0);
                checkOutput("golden_15_busy", {31'b0, ifa.busy}, 32'd1);
                checkOutput("golden_15_bit_count", ifa.bit_count, 32'd15);
            end
        end
        checkOutput("golden_done", {31'b0, ifa.done}, 32'd1);
        checkOutput("golden_busy", {31'b0, ifa.busy}, 32'd0);
        checkOutput("golden_final_strobe", {31'b0, ifa.bit_err_valid}, 32'd1);
        checkOutput("golden_bit_count", ifa.bit_count, 32'd16);
        checkOutput("golden_error_count", ifa.error_count, 32'd0);
        applyStimulus(1'b0, 3'b000, 1'b1, 1'b1);
        checkOutput("frozen_bit_count", ifa.bit_count, 32'd16);
        checkOutput("frozen_bev", {31'b0, ifa.bit_err_valid}, 32'd0);
        checkOutput("frozen_done", {31'b0, ifa.done}, 32'd1);
        checkOutput("golden_strobes", strobe_cnt, 32'd16);

        // Stuck-high stream: only the 16th bit (expected 0) mismatches
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 3'b000, 1'b1, 1'b1);
            if (i == 14) checkOutput("stuck_15_error_count", ifa.error_count, 32'd0);
        end
        checkOutput("stuck_error_count", ifa.error_count, 32'd1);
        checkOutput("stuck_done", {31'b0, ifa.done}, 32'd1);

        // 16QAM with gaps, started the cycle after done rose
        gen_lfsr = 15'h7FFF;
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
        checkOutput("b2b_busy", {31'b0, ifa.busy}, 32'd1);
        checkOutput("b2b_done", {31'b0, ifa.done}, 32'd0);
        for (int k = 0; k < 32; k++) begin
            nextPrbs(b);
            applyStimulus(1'b0, 3'b001, 1'b1, b);
            if (k == 30) checkOutput("qam16_31_done", {31'b0, ifa.done}, 32'd0);
            if (k < 31) applyStimulus(1'b0, 3'b001, 1'b0, 1'($urandom));
        end
        checkOutput("qam16_done", {31'b0, ifa.done}, 32'd1);
        checkOutput("qam16_bit_count", ifa.bit_count, 32'd32);
        checkOutput("qam16_error_count", ifa.error_count, 32'd0);

        // Restart mid-frame after injected errors
        gen_lfsr = 15'h7FFF;
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            nextPrbs(b);
            applyStimulus(1'b0, 3'b000, 1'b1, b ^ ((i == 2) || (i == 5)));
        end
        checkOutput("restart_pre_error_count", ifa.error_count, 32'd2);
        checkOutput("restart_pre_bit_count", ifa.bit_count, 32'd10);
        gen_lfsr = 15'h7FFF;
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        checkOutput("restart_bit_count", ifa.bit_count, 32'd0);
        checkOutput("restart_error_count", ifa.error_count, 32'd0);
        checkOutput("restart_busy", {31'b0, ifa.busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            nextPrbs(b);
            applyStimulus(1'b0, 3'b000, 1'b1, b);
        end
        checkOutput("restart_done", {31'b0, ifa.done}, 32'd1);
        checkOutput("restart_error_count_end", ifa.error_count, 32'd0);
        checkOutput("restart_bit_count_end", ifa.bit_count, 32'd16);

        // Asynchronous reset in the middle of a frame
        gen_lfsr = 15'h7FFF;
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            nextPrbs(b);
            applyStimulus(1'b0, 3'b000, 1'b1, b);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", {31'b0, ifa.busy}, 32'd0);
        checkOutput("arst_done", {31'b0, ifa.done}, 32'd0);
        checkOutput("arst_bev", {31'b0, ifa.bit_err_valid}, 32'd0);
        checkOutput("arst_bit_err", {31'b0, ifa.bit_err}, 32'd0);
        checkOutput("arst_bit_count", ifa.bit_count, 32'd0);
        checkOutput("arst_error_count", ifa.error_count, 32'd0);
        expq.delete();
        model_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'b000, 1'b1, 1'b1);
        checkOutput("post_rst_bev", {31'b0, ifa.bit_err_valid}, 32'd0);
        checkOutput("post_rst_bit_count", ifa.bit_count, 32'd0);
        checkOutput("post_rst_busy", {31'b0, ifa.busy}, 32'd0);
        gen_lfsr = 15'h7FFF;
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            nextPrbs(b);
            applyStimulus(1'b0, 3'b000, 1'b1, b);
        end
        checkOutput("post_rst_done", {31'b0, ifa.done}, 32'd1);
        checkOutput("post_rst_error_count", ifa.error_count, 32'd0);
        @(negedge clk);
        ifa.rx_bit_valid = 1'b0;
        ifa.start        = 1'b0;

        // Saturation on the narrow-counter instance: every bit inverted
        gen_lfsr = 15'h7FFF;
        applySat(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            nextPrbs(b);
            applySat(1'b0, 1'b1, ~b);
            checkOutput("sat_error_count", ifs.error_count, (k + 1 > 15) ? 32'd15 : 32'(k + 1));
        end
        checkOutput("sat_done", {31'b0, ifs.done}, 32'd1);
        checkOutput("sat_busy", {31'b0, ifs.busy}, 32'd0);
        @(negedge clk);
        ifs.rx_bit_valid = 1'b0;

        @(negedge clk);
        #1;
        checkOutput("queue_drained", expq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
